// File: rtl/mpc_vector_scheduler.sv
// MPC switching-vector scheduler: control-period timebase, single-slot vector handshake,
// current-direction debounce and sticky fault clamp feeding the four-step commutation block.
module mpc_vector_scheduler #(
    parameter int TICK_DIV     = 200,
    parameter int PERIOD_TICKS = 20,
    parameter int DEB_LEN      = 8,
    parameter int VEC_MAX      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] vec_in,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic [2:0] idir_raw,
    input  logic       fault_in,
    input  logic       fault_clear,
    output logic [4:0] v,
    output logic [2:0] dir,
    output logic       clamp_signal,
    output logic       interrupt,
    output logic       period_start,
    output logic       missed,
    output logic       bad_vec
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(PERIOD_TICKS);
    localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_TICKS - 1);
    localparam logic [PW-1:0] PERIOD_HALF = PW'(PERIOD_TICKS / 2);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_LEN - 1);
    localparam logic [4:0]    VEC_LAST    = 5'(VEC_MAX);

    logic [TW-1:0] r_tick_cnt;
    logic [PW-1:0] r_period_cnt;
    logic          r_period_start;
    logic          r_interrupt;
    logic          w_tick;
    logic          w_period_end;
    logic [PW-1:0] w_period_cnt_next;

    logic          r_full;
    logic [4:0]    r_pend;
    logic [4:0]    r_v;
    logic          r_missed;
    logic          r_bad_vec;
    logic          r_clamp;
    logic          w_accept;
    logic          w_clamped;

    logic          r_fault_s1;
    logic          r_fault_s;
    logic [2:0]    r_idir_s1;
    logic [2:0]    r_idir_s;
    logic [2:0]    r_dir;
    logic [DW-1:0] r_deb_cnt [3];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_tick            = (r_tick_cnt == TICK_LAST);
        w_period_end      = w_tick && (r_period_cnt == PERIOD_LAST);
        w_period_cnt_next = r_period_cnt;
        if (w_tick) begin
            w_period_cnt_next = w_period_end ? '0 : r_period_cnt + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt     <= '0;
            r_period_cnt   <= '0;
            r_period_start <= 1'b0;
            r_interrupt    <= 1'b0;
        end else begin
            r_tick_cnt     <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_period_cnt   <= w_period_cnt_next;
            r_period_start <= w_period_end;
            // Looking at the next count keeps interrupt edges aligned with period_start.
            r_interrupt    <= (w_period_cnt_next < PERIOD_HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_s1 <= 1'b0;
            r_fault_s  <= 1'b0;
            r_idir_s1  <= '0;
            r_idir_s   <= '0;
        end else begin
            r_fault_s1 <= fault_in;
            r_fault_s  <= r_fault_s1;
            r_idir_s1  <= idir_raw;
            r_idir_s   <= r_idir_s1;
        end
    end

    assign vec_ready = !r_full && !r_clamp && !rst;
    assign w_accept  = vec_valid && vec_ready;
    // A fault seen on the boundary cycle already counts as clamped: the pending vector is dropped.
    assign w_clamped = r_clamp || r_fault_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 1'b0;
            r_pend    <= '0;
            r_v       <= '0;
            r_missed  <= 1'b0;
            r_bad_vec <= 1'b0;
        end else begin
            if (r_period_start && !w_clamped) begin
                if (!r_full) begin
                    r_missed <= 1'b1;
                end else if (r_pend <= VEC_LAST) begin
                    r_v <= r_pend;
                end else begin
                    r_bad_vec <= 1'b1;
                end
            end
            if (r_period_start) begin
                r_full <= 1'b0;
            end
            if (w_accept) begin
                r_full <= 1'b1;
                r_pend <= vec_in;
            end
            if (r_fault_s) begin
                r_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clamp <= 1'b0;
        end else if (r_fault_s) begin
            r_clamp <= 1'b1;
        end else if (fault_clear) begin
            r_clamp <= 1'b0;
        end
    end

    // NOTE: the debounce counters are only a few flops, so they reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_idir_s[i] == r_dir[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_dir[i]     <= ~r_dir[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign v            = r_v;
    assign dir          = r_dir;
    assign clamp_signal = r_clamp;
    assign interrupt    = r_interrupt;
    assign period_start = r_period_start;
    assign missed       = r_missed;
    assign bad_vec      = r_bad_vec;

endmodule

// File: doc/mpc_vector_scheduler.md
Name: mpc_vector_scheduler

Overview:
- Upstream stage of the matrix-converter switch-drive top. Sits between the MPC processor interface and the four-step commutation / clamp block.
- Accepts one optimal switching-vector index per control period through a valid/ready handshake. Applies it on the control-period boundary and debounces the three output-current direction comparators.
- Latches the hardware fault into the clamp request and generates the control-period interrupt that paces the processor.
- Outputs v, dir, clamp_signal and interrupt drive the commutation block directly.

Parameters:
- TICK_DIV, 200, clk cycles per timebase tick (2 us at 100 MHz).
- PERIOD_TICKS, 20, ticks per control period (40 us); must be even and >= 2.
- DEB_LEN, 8, consecutive clk cycles a synchronized direction bit must disagree with dir before dir follows it.
- VEC_MAX, 26, highest legal vector index (27 switching states of a 3x3 converter).

Ports:
- clk  input  1  system clock, 10 ns.
- rst  input  1  synchronous, active-high reset.
- vec_in  input  5  requested switching-vector index.
- vec_valid  input  1  vec_in is valid.
- vec_ready  output  1  scheduler can accept a vector this cycle.
- idir_raw  input  3  asynchronous current-direction comparators, bit i = phase i.
- fault_in  input  1  asynchronous overcurrent/overvoltage fault, active high.
- fault_clear  input  1  request to release the clamp.
- v  output  5  applied vector index to the commutation stage.
- dir  output  3  debounced current direction.
- clamp_signal  output  1  clamp request, sticky.
- interrupt  output  1  control-period square wave to the processor.
- period_start  output  1  one-clk pulse at each control-period boundary.
- missed  output  1  sticky: a period boundary passed with no pending vector.
- bad_vec  output  1  sticky: a vector index > VEC_MAX reached a boundary.

Behaviour:
- Reset values (rst high at a clk edge): v=0, dir=0, clamp_signal=0, interrupt=0, period_start=0, missed=0, bad_vec=0, vec_ready=0. All counters, the pending register and synchronizers are cleared. vec_ready rises on the first cycle after rst is released.
- Timebase:
  - tick_cnt counts 0..TICK_DIV-1; tick is asserted when tick_cnt==TICK_DIV-1.
  - period_cnt advances on tick and wraps from PERIOD_TICKS-1 to 0.
  - period_start is a registered pulse, high for one clk on the cycle after tick with period_cnt==PERIOD_TICKS-1.
  - The first period_start comes TICK_DIV*PERIOD_TICKS cycles after reset release.
  - interrupt is registered: high while period_cnt < PERIOD_TICKS/2, low otherwise, giving a 50 % duty cycle. It may be 0 for the first cycle after reset, then reflects the rule.
- Vector handshake:
  - Single pending register with a full flag.
  - vec_ready = !full && !clamp_signal.
  - A transfer occurs when vec_valid && vec_ready; vec_in is stored and full is set on the next edge.
  - vec_in is not checked at acceptance.
- Period boundary (period_start cycle):
  - If full and pending <= VEC_MAX: v is set to pending and full is cleared.
  - If full and pending > VEC_MAX: v holds, bad_vec is set, full is cleared.
  - If not full: v holds and missed is set.
  - The boundary acts on the register state before this edge. A transfer completing on the same edge is kept for the next boundary, and missed is still set.
  - v changes only on period_start cycles, or to 0 on reset.
- Direction debounce:
  - Each idir_raw bit passes through a 2-FF synchronizer.
  - A per-phase counter increments while the sync bit != dir[i] and resets to 0 when they match.
  - When the counter reaches DEB_LEN-1 while still mismatched, dir[i] toggles and the counter resets.
  - Total latency from a stable raw change to dir: 2 sync + DEB_LEN cycles.
  - Glitches shorter than DEB_LEN are ignored. Phases are independent.
- Fault / clamp:
  - fault_in passes through a 2-FF synchronizer (fault_s).
  - fault_s=1 sets clamp_signal on the next edge and clears full, discarding the pending vector.
  - clamp_signal stays set until fault_clear=1 while fault_s=0; it then clears on the next edge. fault_clear is ignored while fault_s=1.
  - While clamped, boundaries still occur but are not flagged as missed, and v holds.
  - The timebase and debounce keep running through a fault.
- missed and bad_vec clear only on rst.
- rst mid-period restarts the timebase from 0. A pending vector is lost.

Test Plan (TICK_DIV=4, PERIOD_TICKS=4, DEB_LEN=3, so period = 16 clk):
- Reset then idle 40 clk -> period_start pulses at cycles 16 and 32 after release; interrupt high 8 / low 8; missed=1 after the first boundary; v=0.
- Send vec_in=13 at cycle 3 -> vec_ready drops the next cycle; v=13 on the cycle after the first period_start; vec_ready returns high; missed=0.
- Send vec_in=27 -> at the boundary v holds its previous value, bad_vec=1, vec_ready re-asserts.
- Transfer vec_in=5 on the same edge as a boundary with empty pending -> missed=1, v unchanged; v=5 after the next boundary.
- Glitches on idir_raw[1]: 2-cycle glitch -> dir stays 0; level held 10 cycles -> dir[1]=1 exactly 5 cycles after the raw change.
- fault_in high 3 cycles with a vector pending -> clamp_signal=1 three cycles after the raw rise; vec_ready=0; pending dropped (v unchanged at the next boundary); fault_clear during the fault is ignored; fault_clear after the fault -> clamp_signal=0 next edge.
